bridge_fc_monitor: RTL and testbench
====================================

# bridge_fc_monitor

Parametrised flow-credit monitor for the PCIe bridge transmit path. Samples the core's transmit-available credit counters and keeps a local shadow count per credit type, decremented by bridge transmit events between core refreshes. Issues per-type go/no-go flags with hysteresis to the transmit bridge. Sits between the core's fc_* sideband and the transmit bridge module, replacing the purely combinational credit check.

## Interface
- HDR_W, 8: header credit counter width
- DATA_W, 12: data credit counter width (16-byte units)
- HDR_MIN, 1: header credits required to allow a TLP type
- DATA_MIN, 32: data credits required, one max-payload TLP (512 B)
- HYST, 4: extra credits above MIN needed to re-assert a flag
- SEL_LAT, 2: cycles from Fc_sel stable to valid fc_* data
- REFRESH, 64: RUN cycles between core re-samples, ≥ SEL_LAT+1
- INF_MASK, 6'b000000: per-flag force-on for types advertised infinite
- Fc_CLK  in  1  sole clock
- Fc_RST  in  1  asynchronous, active-low reset
- Fc_Link_Up  in  1  core link up
- Fc_ph / Fc_nph / Fc_cplh  in  HDR_W each  core header credits
- Fc_pd / Fc_npd / Fc_cpld  in  DATA_W each  core data credits
- Fc_Cons_Vld  in  1  one TLP handed to core this cycle
- Fc_Cons_Type  in  2  0 = posted, 1 = non-posted, 2 = completion, 3 = ignored
- Fc_Cons_Data  in  DATA_W  data credits used by that TLP; 0 if no payload
- Fc_sel  out  3  flow-control select to core; constant 3'b100 (transmit available)
- Fc_Tx_FC  out  6  go flags: [0] ph, [1] pd, [2] nph, [3] npd, [4] cplh, [5] cpld
- Fc_Ready  out  1  shadow counts valid (RUN state)

## Operation
- **States:** IDLE, WAIT, RUN. Reset state is IDLE.
- **IDLE:**
  - Counters are 0, Fc_Tx_FC = 0, Fc_Ready = 0.
  - Moves to WAIT on the first cycle Fc_Link_Up = 1.
- **WAIT:**
  - Delay counter runs SEL_LAT cycles.
  - On the edge leaving WAIT, all six shadow counters load from the core inputs, and the FSM enters RUN.
- **RUN:**
  - A refresh counter counts 0 … REFRESH-1 and wraps.
  - At count REFRESH-1, all shadow counters reload from the core inputs.
  - Fc_Ready = 1.
- **Link drop:** Fc_Link_Up = 0 in any state sends the FSM to IDLE on the next edge. Counters, flags and the refresh counter clear on that same edge.
- **Consumption (RUN only, Fc_Cons_Vld = 1):**
  - The selected type's header counter decrements by 1.
  - The selected type's data counter decrements by Fc_Cons_Data.
  - Both subtractions saturate at 0.
  - Type 3 is ignored.
  - Consumption is ignored in IDLE and WAIT.
- **Refresh and consume in the same cycle:** the counter loads the core value minus the consumption, saturating.
- **Flags (per bit, against the next-state counter value):**
  - Set when count ≥ MIN + HYST.
  - Clear when count < MIN.
  - Otherwise hold.
  - MIN/HYST is HDR_* for header bits and DATA_* for data bits.
  - On entry to RUN, a flag sets only if the loaded value is ≥ MIN + HYST.
- **INF_MASK:** a masked bit reads 1 whenever Fc_Ready = 1, and 0 otherwise.
- **Arithmetic width:** MIN + HYST is evaluated one bit wider than the counter, so values that don't fit never assert.

## Timing
- **Reset values:** Fc_sel = 3'b100, Fc_Tx_FC = 6'b0, Fc_Ready = 0, all counters 0.
- Reset assertion is asynchronous; release is sampled on the Fc_CLK rising edge.
- Fc_sel never changes.
- **Link up to Ready:** Fc_Link_Up high at edge N gives WAIT from N+1. Counters load and Fc_Ready = 1 at edge N+1+SEL_LAT.
- **Consume to flag:** a consume pulse at edge N updates the counter and Fc_Tx_FC on edge N+1. This is a single-cycle response with no extra pipeline stage.
- Back-to-back Fc_Cons_Vld on every cycle is supported.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset:** assert Fc_RST = 0 mid-clock.
  - Outputs go to their reset values immediately (Fc_Tx_FC = 0, Fc_sel = 3'b100).
  - After release with link down, the FSM stays in IDLE.
- **Startup:** Fc_ph = 8, Fc_pd = 100, others 0; raise Fc_Link_Up.
  - Fc_Ready rises 3 cycles later.
  - Fc_Tx_FC = 6'b000011.
- **Hysteresis:** pd = 37; consume posted with Data = 6.
  - pd = 31, so bit 1 clears.
  - Refresh to pd = 35: bit 1 stays 0.
  - Refresh to pd = 36: bit 1 sets.
- **Saturation and refresh collision:** nph = 1; consume NP twice back to back.
  - nph = 0 with no wrap.
  - With a consume on the refresh cycle and core nph = 10, the counter loads 9.
- **Link drop mid-RUN:** with a consume pending, drop Fc_Link_Up.
  - Next edge: Fc_Ready = 0, Fc_Tx_FC = 0, counters 0.
  - Re-raising the link repeats the WAIT timing.
- **INF_MASK = 6'b110000:** core cplh/cpld = 0.
  - Bits 5:4 = 1 while Ready.
  - Both bits drop to 0 on link down.

Source files
------------

// File: rtl/bridge_fc_monitor.sv
// bridge_fc_monitor: transmit flow-credit monitor between the core fc_* sideband
// and the transmit bridge. The block samples the core's transmit-available credit
// counters and keeps six shadow counts. Bridge consume events decrement those
// counts between core refreshes. The block drives per-type go flags with hysteresis.
//
// Ports:
//   Fc_CLK, Fc_RST              clock, async active-low reset
//   Fc_Link_Up                  core link up; low returns the monitor to IDLE
//   Fc_ph/nph/cplh              core header credits (HDR_W)
//   Fc_pd/npd/cpld              core data credits (DATA_W, 16-byte units)
//   Fc_Cons_Vld/Type/Data       one TLP handed to the core this cycle
//   Fc_sel                      constant transmit-available select to core
//   Fc_Tx_FC                    go flags {cpld,cplh,npd,nph,pd,ph}
//   Fc_Ready                    shadow counts valid
module bridge_fc_monitor #(
  parameter int unsigned HDR_W    = 8,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned HDR_MIN  = 1,
  parameter int unsigned DATA_MIN = 32,
  parameter int unsigned HYST     = 4,
  parameter int unsigned SEL_LAT  = 2,
  parameter int unsigned REFRESH  = 64,
  parameter logic [5:0]  INF_MASK = 6'b000000
) (
  input  logic              Fc_CLK,
  input  logic              Fc_RST,
  input  logic              Fc_Link_Up,
  input  logic [HDR_W-1:0]  Fc_ph,
  input  logic [HDR_W-1:0]  Fc_nph,
  input  logic [HDR_W-1:0]  Fc_cplh,
  input  logic [DATA_W-1:0] Fc_pd,
  input  logic [DATA_W-1:0] Fc_npd,
  input  logic [DATA_W-1:0] Fc_cpld,
  input  logic              Fc_Cons_Vld,
  input  logic [1:0]        Fc_Cons_Type,
  input  logic [DATA_W-1:0] Fc_Cons_Data,
  output logic [2:0]        Fc_sel,
  output logic [5:0]        Fc_Tx_FC,
  output logic              Fc_Ready
);

  localparam int unsigned DLY_W   = (SEL_LAT > 0) ? $clog2(SEL_LAT + 1) : 1;
  localparam int unsigned REF_W   = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned HDR_XW  = HDR_W + 1;
  localparam int unsigned DATA_XW = DATA_W + 1;

  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(SEL_LAT);
  localparam logic [REF_W-1:0]   REF_LAST = REF_W'(REFRESH - 1);
  localparam logic [HDR_XW-1:0]  HDR_CLR  = HDR_XW'(HDR_MIN);
  localparam logic [HDR_XW-1:0]  HDR_SET  = HDR_XW'(HDR_MIN + HYST);
  localparam logic [DATA_XW-1:0] DATA_CLR = DATA_XW'(DATA_MIN);
  localparam logic [DATA_XW-1:0] DATA_SET = DATA_XW'(DATA_MIN + HYST);
  localparam logic [2:0]         SEL_TXAV = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} state_e;

  state_e                   state_q, state_d;
  logic [DLY_W-1:0]         dly_q, dly_d;
  logic [REF_W-1:0]         ref_q, ref_d;
  logic [2:0][HDR_W-1:0]    hdr_q, hdr_d;
  logic [2:0][DATA_W-1:0]   data_q, data_d;
  logic [5:0]               tx_fc_q, tx_fc_d;
  logic                     ready_q, ready_d;
  logic [2:0]               sel_q;
  logic                     load_c;
  logic [2:0]               cons_c;
  logic [2:0][HDR_W-1:0]    core_hdr_c;
  logic [2:0][DATA_W-1:0]   core_data_c;

  // Index 0 = posted, 1 = non-posted, 2 = completion (matches Fc_Cons_Type).
  assign core_hdr_c  = {Fc_cplh, Fc_nph, Fc_ph};
  assign core_data_c = {Fc_cpld, Fc_npd, Fc_pd};

  function automatic logic [HDR_W-1:0] sub_hdr(input logic [HDR_W-1:0] a, input logic b);
    return (a >= HDR_W'(b)) ? a - HDR_W'(b) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] sub_data(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

  function automatic logic hyst_hdr(input logic [HDR_W-1:0] v, input logic old);
    logic [HDR_XW-1:0] x;
    x = {1'b0, v};
    if (x >= HDR_SET)     return 1'b1;
    else if (x < HDR_CLR) return 1'b0;
    else                  return old;
  endfunction

  function automatic logic hyst_data(input logic [DATA_W-1:0] v, input logic old);
    logic [DATA_XW-1:0] x;
    x = {1'b0, v};
    if (x >= DATA_SET)     return 1'b1;
    else if (x < DATA_CLR) return 1'b0;
    else                   return old;
  endfunction

  // State and shadow registers.
  always_ff @(posedge Fc_CLK or negedge Fc_RST) begin
    if (!Fc_RST) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      ref_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      tx_fc_q <= '0;
      ready_q <= 1'b0;
      sel_q   <= SEL_TXAV;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ref_q   <= ref_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      tx_fc_q <= tx_fc_d;
      ready_q <= ready_d;
      sel_q   <= SEL_TXAV;
    end
  end

  // Next state, delay/refresh counters and the core-sample strobe.
  // WAIT covers the entry cycle plus SEL_LAT settle cycles before sampling.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ref_d   = ref_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Fc_Link_Up) begin
          state_d = ST_WAIT;
          dly_d   = '0;
        end
      end
      ST_WAIT: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_RUN;
          load_c  = 1'b1;
          ref_d   = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_RUN: begin
        load_c = (ref_q == REF_LAST);
        ref_d  = load_c ? '0 : ref_q + REF_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (!Fc_Link_Up) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      ref_d   = '0;
      load_c  = 1'b0;
    end
  end

  // Consume decode; type 3 never matches.
  always_comb begin
    cons_c = '0;
    for (int t = 0; t < 3; t++) begin
      cons_c[t] = (state_q == ST_RUN) && Fc_Cons_Vld && (Fc_Cons_Type == 2'(t));
    end
  end

  // Shadow counters and flags; flags track the next-state count so a consume
  // is reflected one edge later.
  always_comb begin
    hdr_d   = '0;
    data_d  = '0;
    tx_fc_d = '0;
    ready_d = (state_d == ST_RUN);
    if (state_d == ST_RUN) begin
      for (int t = 0; t < 3; t++) begin
        hdr_d[t]  = sub_hdr(load_c ? core_hdr_c[t] : hdr_q[t], cons_c[t]);
        data_d[t] = sub_data(load_c ? core_data_c[t] : data_q[t],
                             cons_c[t] ? Fc_Cons_Data : '0);
        tx_fc_d[2*t]   = hyst_hdr(hdr_d[t], tx_fc_q[2*t]);
        tx_fc_d[2*t+1] = hyst_data(data_d[t], tx_fc_q[2*t+1]);
      end
      tx_fc_d = tx_fc_d | INF_MASK;
    end
  end

  assign Fc_sel   = sel_q;
  assign Fc_Tx_FC = tx_fc_q;
  assign Fc_Ready = ready_q;

endmodule

// File: tb/tb_bridge_fc_monitor.sv
// Directed bench for bridge_fc_monitor: one default instance and one with
// completion credits forced infinite, driven from shared stimulus.
module tb_bridge_fc_monitor;

  localparam int unsigned HDR_W  = 8;
  localparam int unsigned DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              link_up;
  logic [HDR_W-1:0]  ph, nph, cplh;
  logic [DATA_W-1:0] pd, npd, cpld;
  logic              cons_vld;
  logic [1:0]        cons_type;
  logic [DATA_W-1:0] cons_data;
  logic [2:0]        sel, sel_inf;
  logic [5:0]        tx_fc, tx_fc_inf;
  logic              ready, ready_inf;

  int n_chk  = 0;
  int n_fail = 0;
  int tb_ref = 0;

  always #5 clk = ~clk;

  bridge_fc_monitor dut (
    .Fc_CLK(clk), .Fc_RST(rst_n), .Fc_Link_Up(link_up),
    .Fc_ph(ph), .Fc_nph(nph), .Fc_cplh(cplh),
    .Fc_pd(pd), .Fc_npd(npd), .Fc_cpld(cpld),
    .Fc_Cons_Vld(cons_vld), .Fc_Cons_Type(cons_type), .Fc_Cons_Data(cons_data),
    .Fc_sel(sel), .Fc_Tx_FC(tx_fc), .Fc_Ready(ready)
  );

  bridge_fc_monitor #(.INF_MASK(6'b110000)) dut_inf (
    .Fc_CLK(clk), .Fc_RST(rst_n), .Fc_Link_Up(link_up),
    .Fc_ph(ph), .Fc_nph(nph), .Fc_cplh(cplh),
    .Fc_pd(pd), .Fc_npd(npd), .Fc_cpld(cpld),
    .Fc_Cons_Vld(cons_vld), .Fc_Cons_Type(cons_type), .Fc_Cons_Data(cons_data),
    .Fc_sel(sel_inf), .Fc_Tx_FC(tx_fc_inf), .Fc_Ready(ready_inf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; tb_ref mirrors the expected refresh count while running.
  task automatic step();
    @(posedge clk);
    #1;
    tb_ref = (tb_ref + 1) % 64;
  endtask

  // Advance until the next edge is a refresh edge (bounded by the period).
  task automatic to_refresh();
    for (int i = 0; i < 64 && tb_ref != 63; i++) step();
  endtask

  task automatic consume(input logic [1:0] typ, input logic [DATA_W-1:0] d);
    cons_vld  = 1'b1;
    cons_type = typ;
    cons_data = d;
  endtask

  task automatic idle_cons();
    cons_vld  = 1'b0;
    cons_type = 2'd0;
    cons_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; link_up = 1'b0;
    ph = '0; nph = '0; cplh = '0; pd = '0; npd = '0; cpld = '0;
    idle_cons();

    // Reset, then link down keeps IDLE
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_ready", 8'(ready), 8'h00);
    chk("idle_tx", 8'(tx_fc), 8'h00);
    chk("idle_sel", 8'(sel), 8'h04);
    chk("idle_tx_inf", 8'(tx_fc_inf), 8'h00);

    // Startup: ready three edges after link sampled
    ph = 8'd8; pd = 12'd100;
    link_up = 1'b1;
    step();
    chk("wait_ready0", 8'(ready), 8'h00);
    step(); step();
    chk("wait_ready2", 8'(ready), 8'h00);
    step();
    tb_ref = 0;
    chk("start_ready", 8'(ready), 8'h01);
    chk("start_tx", 8'(tx_fc), 8'h03);
    chk("start_tx_inf", 8'(tx_fc_inf), 8'h33);
    chk("run_sel", 8'(sel), 8'h04);

    // Hysteresis on pd
    pd = 12'd37;
    to_refresh(); step();
    chk("pd37_tx", 8'(tx_fc), 8'h03);
    consume(2'd0, 12'd6); step(); idle_cons();
    chk("pd31_clear", 8'(tx_fc), 8'h01);
    pd = 12'd35;
    to_refresh(); step();
    chk("pd35_hold", 8'(tx_fc), 8'h01);
    pd = 12'd36;
    to_refresh(); step();
    chk("pd36_set", 8'(tx_fc), 8'h03);
    chk("pd36_set_inf", 8'(tx_fc_inf), 8'h33);

    // Back-to-back posted consumes: 36 -> 34 -> 32 -> 30
    consume(2'd0, 12'd2); step(); step();
    chk("pd32_at_min", 8'(tx_fc), 8'h03);
    step(); idle_cons();
    chk("pd30_below", 8'(tx_fc), 8'h01);

    // Header saturation at zero
    nph = 8'd1;
    to_refresh(); step();
    chk("nph1_tx", 8'(tx_fc), 8'h03);
    consume(2'd1, 12'd0); step();
    chk("nph_sat1", 8'(tx_fc), 8'h03);
    step(); idle_cons();
    chk("nph_sat2", 8'(tx_fc), 8'h03);

    // Refresh/consume collision: loads core minus consumption
    nph = 8'd5; npd = 12'd36;
    to_refresh(); consume(2'd1, 12'd1); step(); idle_cons();
    chk("collide_sub", 8'(tx_fc), 8'h03);
    nph = 8'd10; npd = 12'd40;
    to_refresh(); consume(2'd1, 12'd1); step(); idle_cons();
    chk("collide_load", 8'(tx_fc), 8'h0f);

    // Type 3 is ignored
    consume(2'd3, 12'd40); step(); idle_cons();
    chk("type3_ignored", 8'(tx_fc), 8'h0f);

    // Link drop with a consume pending
    consume(2'd0, 12'd6); link_up = 1'b0;
    step(); idle_cons();
    chk("drop_ready", 8'(ready), 8'h00);
    chk("drop_tx", 8'(tx_fc), 8'h00);
    chk("drop_tx_inf", 8'(tx_fc_inf), 8'h00);
    chk("drop_ready_inf", 8'(ready_inf), 8'h00);

    // Relink repeats WAIT timing
    link_up = 1'b1;
    step(); step(); step();
    chk("relink_wait", 8'(ready), 8'h00);
    step();
    tb_ref = 0;
    chk("relink_ready", 8'(ready), 8'h01);
    chk("relink_tx", 8'(tx_fc), 8'h0f);
    chk("relink_tx_inf", 8'(tx_fc_inf), 8'h3f);

    // Asynchronous reset mid-clock
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx", 8'(tx_fc), 8'h00);
    chk("arst_ready", 8'(ready), 8'h00);
    chk("arst_sel", 8'(sel), 8'h04);
    chk("arst_tx_inf", 8'(tx_fc_inf), 8'h00);
    link_up = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk("post_rst_ready", 8'(ready), 8'h00);
    chk("post_rst_tx", 8'(tx_fc), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
